// File: rtl/sc_regrot_if.sv
// Bundle of control, data and status signals between the lane pattern loader
// and the rotating display register.
interface sc_regrot_if #(
  parameter int DATAWIDTH_BUS   = 8,
  parameter int PRESCALER_WIDTH = 8
);
  logic                       SC_REGROT_LOAD;
  logic [DATAWIDTH_BUS-1:0]   SC_REGROT_DATAPARALLEL_BUS_IN;
  logic                       SC_REGROT_ENABLE;
  logic                       SC_REGROT_STEP;
  logic                       SC_REGROT_DIR;
  logic                       SC_REGROT_MODE;
  logic                       SC_REGROT_SERIAL_IN;
  logic [PRESCALER_WIDTH-1:0] SC_REGROT_PERIOD;
  logic [DATAWIDTH_BUS-1:0]   SC_REGROT_DATAPARALLEL_BUS_OUT;
  logic                       SC_REGROT_SERIAL_OUT;
  logic                       SC_REGROT_LOADED;
  logic                       SC_REGROT_TICK;
  logic                       SC_REGROT_WRAP;

  modport master (
    output SC_REGROT_LOAD, SC_REGROT_DATAPARALLEL_BUS_IN, SC_REGROT_ENABLE,
           SC_REGROT_STEP, SC_REGROT_DIR, SC_REGROT_MODE, SC_REGROT_SERIAL_IN,
           SC_REGROT_PERIOD,
    input  SC_REGROT_DATAPARALLEL_BUS_OUT, SC_REGROT_SERIAL_OUT,
           SC_REGROT_LOADED, SC_REGROT_TICK, SC_REGROT_WRAP
  );

  modport slave (
    input  SC_REGROT_LOAD, SC_REGROT_DATAPARALLEL_BUS_IN, SC_REGROT_ENABLE,
           SC_REGROT_STEP, SC_REGROT_DIR, SC_REGROT_MODE, SC_REGROT_SERIAL_IN,
           SC_REGROT_PERIOD,
    output SC_REGROT_DATAPARALLEL_BUS_OUT, SC_REGROT_SERIAL_OUT,
           SC_REGROT_LOADED, SC_REGROT_TICK, SC_REGROT_WRAP
  );
endinterface

// File: rtl/sc_regrot.sv
// Rotating / serial-fill display register with load priority, manual step,
// prescaled autonomous scrolling and per-shift / per-lap status pulses.
module sc_regrot #(
  parameter int                       DATAWIDTH_BUS   = 8,
  parameter int                       PRESCALER_WIDTH = 8,
  parameter logic [DATAWIDTH_BUS-1:0] RESET_VALUE     = '0
) (
  input logic        SC_REGROT_CLOCK,
  input logic        SC_REGROT_RESET_InLow,
  sc_regrot_if.slave rot
);

  localparam int LAP_W = (DATAWIDTH_BUS > 1) ? $clog2(DATAWIDTH_BUS) : 1;
  localparam logic [LAP_W-1:0] LAP_LAST = LAP_W'(DATAWIDTH_BUS - 1);

  logic [DATAWIDTH_BUS-1:0]   data_q;
  logic [DATAWIDTH_BUS-1:0]   shifted;
  logic [PRESCALER_WIDTH-1:0] presc_q;
  logic [LAP_W-1:0]           lap_q;
  logic                       tick_q;
  logic                       wrap_q;
  logic                       serial_out;
  logic                       fill;
  logic                       auto_evt;
  logic                       shift_evt;
  logic                       lap_last;

  assign serial_out = rot.SC_REGROT_DIR ? data_q[DATAWIDTH_BUS-1] : data_q[0];
  assign fill       = rot.SC_REGROT_MODE ? rot.SC_REGROT_SERIAL_IN : serial_out;
  assign shifted    = rot.SC_REGROT_DIR ? {data_q[DATAWIDTH_BUS-2:0], fill}
                                        : {fill, data_q[DATAWIDTH_BUS-1:1]};

  // >= rather than == so a PERIOD lowered mid-count fires on the next edge.
  assign auto_evt  = rot.SC_REGROT_ENABLE && (presc_q >= rot.SC_REGROT_PERIOD);
  assign shift_evt = rot.SC_REGROT_STEP || auto_evt;
  assign lap_last  = (lap_q == LAP_LAST);

  always_ff @(posedge SC_REGROT_CLOCK or negedge SC_REGROT_RESET_InLow) begin
    if (!SC_REGROT_RESET_InLow) begin
      data_q  <= RESET_VALUE;
      presc_q <= '0;
      lap_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (rot.SC_REGROT_LOAD) begin
      data_q  <= rot.SC_REGROT_DATAPARALLEL_BUS_IN;
      presc_q <= '0;
      lap_q   <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      // Manual steps leave the prescaler alone so auto cadence is preserved.
      if (!rot.SC_REGROT_ENABLE || auto_evt) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + PRESCALER_WIDTH'(1);
      end

      if (shift_evt) begin
        data_q <= shifted;
        tick_q <= 1'b1;
        wrap_q <= lap_last;
        lap_q  <= lap_last ? '0 : lap_q + LAP_W'(1);
      end else begin
        tick_q <= 1'b0;
        wrap_q <= 1'b0;
      end
    end
  end

  assign rot.SC_REGROT_DATAPARALLEL_BUS_OUT = data_q;
  assign rot.SC_REGROT_SERIAL_OUT           = serial_out;
  assign rot.SC_REGROT_LOADED               = (data_q == rot.SC_REGROT_DATAPARALLEL_BUS_IN);
  assign rot.SC_REGROT_TICK                 = tick_q;
  assign rot.SC_REGROT_WRAP                 = wrap_q;

endmodule
